// File: rtl/switch_in.sv
// Debounced 16-bit board switch input with IO read port.
// Ports: clock, rst (async active-low), sw_raw, swcs, swread,
// swaddr (00=data, 10=status), swrdata, sw_changed.
// Macro SWITCH_DEBOUNCE_EN enables the stability counter;
// when undefined the synchronized level is taken every edge.
module switch_in #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] sw_raw,
  input  logic        swcs,
  input  logic        swread,
  input  logic [1:0]  swaddr,
  output logic [15:0] swrdata,
  output logic        sw_changed
);

  logic [15:0] sync1;
  logic [15:0] sync2;
  logic [15:0] deb;
  logic [15:0] deb_nxt;
  logic        load;
  logic        data_rd;
  logic        stat_rd;

  assign data_rd = swcs & swread
                 & (swaddr == 2'b00);
  assign stat_rd = swcs & swread
                 & (swaddr == 2'b10);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CNT_W =
    $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [15:0]      cand;
  logic [CNT_W-1:0] cnt;

  // Any difference restarts the window;
  // the count parks at CNT_MAX once stable.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign load    = (cnt == CNT_MAX)
                 & (cand != deb);
  assign deb_nxt = cand;
`else
  assign load    = (sync2 != deb);
  assign deb_nxt = sync2;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      deb <= '0;
    end else if (load) begin
      deb <= deb_nxt;
    end
  end

  // A new acceptance outranks the
  // clear from a coincident data read.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sw_changed <= 1'b0;
    end else if (load) begin
      sw_changed <= 1'b1;
    end else if (data_rd) begin
      sw_changed <= 1'b0;
    end
  end

  always_comb begin
    swrdata = 16'h0000;
    unique case (1'b1)
      data_rd: swrdata = deb;
      stat_rd: swrdata = {15'b0, sw_changed};
      default: swrdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_switch_in.sv
// Directed scoreboard bench for switch_in.
// Runs with DEBOUNCE_CYCLES=4 in either macro build.
module tb_switch_in;

  localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int LAT = DC + 3;
`else
  localparam int LAT = 3;
`endif

  logic        clock;
  logic        rst;
  logic [15:0] sw_raw;
  logic        swcs;
  logic        swread;
  logic [1:0]  swaddr;
  logic [15:0] swrdata;
  logic        sw_changed;

  switch_in #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .swcs      (swcs),
    .swread    (swread),
    .swaddr    (swaddr),
    .swrdata   (swrdata),
    .sw_changed(sw_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag,
                      input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: got %h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: got %h required %h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic obs_rd(input string tag,
                        input logic [15:0] v);
    push(tag, v);
    compare(swrdata);
  endtask

  task automatic flag(input string tag,
                      input logic v);
    push(tag, {15'b0, v});
    compare({15'b0, sw_changed});
  endtask

  task automatic rd(input logic [1:0] a,
                    input string tag,
                    input logic [15:0] v);
    swcs   = 1'b1;
    swread = 1'b1;
    swaddr = a;
    #1;
    obs_rd(tag, v);
    swcs   = 1'b0;
    swread = 1'b0;
    swaddr = 2'b00;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    sw_raw = 16'hFFFF;
    swcs   = 1'b1;
    swread = 1'b1;
    swaddr = 2'b00;
    step(3);
    obs_rd("rst_data", 16'h0000);
    flag("rst_flag", 1'b0);
    swaddr = 2'b10;
    #1;
    obs_rd("rst_status", 16'h0000);
    swcs   = 1'b0;
    swread = 1'b0;
    swaddr = 2'b00;
    sw_raw = 16'h0000;
    #1;
    rst = 1'b1;
    step(LAT + 4);
    rd(2'b10, "idle_status", 16'h0000);
    rd(2'b00, "idle_data", 16'h0000);

    // stable change, acceptance edge
    sw_raw = 16'hA5A5;
    step(LAT - 1);
    rd(2'b10, "chg_early_st", 16'h0000);
    flag("chg_early_flag", 1'b0);
    step(1);
    rd(2'b10, "chg_status", 16'h0001);
    flag("chg_flag", 1'b1);

    // read strobe without select
    swcs   = 1'b0;
    swread = 1'b1;
    swaddr = 2'b00;
    #1;
    obs_rd("nosel_data", 16'h0000);
    step(1);
    swread = 1'b0;
    flag("nosel_keep", 1'b1);
    rd(2'b01, "bad_addr", 16'h0000);

    // status read held over an edge
    swcs   = 1'b1;
    swread = 1'b1;
    swaddr = 2'b10;
    step(1);
    obs_rd("stat_noclr", 16'h0001);
    flag("stat_noclr_f", 1'b1);
    swaddr = 2'b00;
    #1;
    obs_rd("data_rd", 16'hA5A5);
    step(1);
    flag("data_clr", 1'b0);
    swcs   = 1'b0;
    swread = 1'b0;

`ifdef SWITCH_DEBOUNCE_EN
    sw_raw = 16'hA5A4;
    step(3);
    sw_raw = 16'hA5A5;
    for (int i = 0; i < 20; i++) begin
      step(1);
      flag("glitch_flag", 1'b0);
    end
    rd(2'b00, "glitch_data", 16'hA5A5);
`else
    sw_raw = 16'hA5A4;
    swcs   = 1'b1;
    swread = 1'b1;
    swaddr = 2'b00;
    step(1);
    sw_raw = 16'hA5A5;
    step(2);
    obs_rd("glitch_deb", 16'hA5A4);
    flag("glitch_set", 1'b1);
    step(1);
    obs_rd("glitch_back", 16'hA5A5);
    flag("glitch_set2", 1'b1);
    step(1);
    flag("glitch_clr", 1'b0);
    swcs   = 1'b0;
    swread = 1'b0;
    step(4);
`endif

    // data read coincides with acceptance
    sw_raw = 16'h5A5A;
    swcs   = 1'b1;
    swread = 1'b1;
    swaddr = 2'b00;
    step(LAT - 1);
    obs_rd("coin_old", 16'hA5A5);
    flag("coin_pre", 1'b0);
    step(1);
    flag("coin_set", 1'b1);
    obs_rd("coin_new", 16'h5A5A);
    step(1);
    flag("coin_clr", 1'b0);
    swcs   = 1'b0;
    swread = 1'b0;
    step(2);

    // reset in the middle of a count
    sw_raw = 16'h00FF;
    step(4);
    rst = 1'b0;
    #1;
    rd(2'b00, "rstmid_data", 16'h0000);
    flag("rstmid_flag", 1'b0);
    step(2);
    rd(2'b00, "rstlow_data", 16'h0000);
    flag("rstlow_flag", 1'b0);
    rst = 1'b1;
    step(LAT - 1);
    rd(2'b10, "rel_early_st", 16'h0000);
    rd(2'b00, "rel_early_d", 16'h0000);
    step(1);
    rd(2'b10, "rel_status", 16'h0001);
    rd(2'b00, "rel_data", 16'h00FF);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL sb_leftover: got %0d required 0",
             sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_in.md
SWITCH_IN -- requirements
Module: switch_in

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000; number of consecutive clock cycles the synchronized switch value SHALL remain stable before it is accepted (legal range 2..2^20).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; one clock, no other clock domain.
REQ-004 sw_raw  input  16  raw board switch levels, asynchronous to clock.
REQ-005 swcs  input  1  switch device selected by the memory/IO address decode.
REQ-006 swread  input  1  IO read strobe from the controller, active high.
REQ-007 swaddr  input  2  register select: 2'b00 = switch data, 2'b10 = status.
REQ-008 swrdata  output  16  read data returned to the IO read path.
REQ-009 sw_changed  output  1  sticky "new switch value accepted, not yet read" flag.

Function
REQ-010 sw_raw SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Candidate register cand and counter cnt (width ceil(log2(DEBOUNCE_CYCLES))) SHALL be kept. When sync2 != cand: cand <= sync2, cnt <= 0. Otherwise cnt increments and saturates at DEBOUNCE_CYCLES-1.
REQ-012 When cnt == DEBOUNCE_CYCLES-1 and cand != deb, the next edge SHALL load deb <= cand and set sw_changed <= 1.
REQ-013 Latency: for a raw change held stable, deb SHALL update on the (DEBOUNCE_CYCLES+3)-th rising edge after the change.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change deb or sw_changed.
REQ-015 A return to the old value before acceptance SHALL restart the count, and deb SHALL stay unchanged.
REQ-016 swrdata is combinational so a load completes in the same cycle:
- swcs & swread & swaddr==2'b00 -> deb
- swcs & swread & swaddr==2'b10 -> {15'b0, sw_changed}
- any other address or no select -> 16'h0000
REQ-017 A data read (swcs & swread & swaddr==2'b00) SHALL clear sw_changed on the next edge. A status read SHALL NOT clear it.
REQ-018 If a data read coincides with a deb update on the same edge, the set SHALL win: sw_changed = 1, and swrdata in that cycle shows the old deb.
REQ-019 swread without swcs SHALL have no effect on any state.

Reset
REQ-020 When rst is low, the block SHALL asynchronously force sync1, sync2, cand, deb to 16'h0000, cnt to 0, and sw_changed to 0, so that swrdata reads 16'h0000.
REQ-021 Reset asserted mid-count SHALL discard the pending candidate; after release, debounce restarts from the current sw_raw level.
REQ-022 Release of rst SHALL take effect at the first rising edge after deassertion; no state changes while rst is low.

Configuration
REQ-023 Macro SWITCH_DEBOUNCE_EN:
- Defined: REQ-011..REQ-015 apply.
- Undefined: cand and cnt are removed, and deb <= sync2 every edge (latency 2 edges, visible after the 3rd). sw_changed is set on any edge where sync2 != deb. All other requirements still hold.

Verification (DEBOUNCE_CYCLES=4, SWITCH_DEBOUNCE_EN defined unless noted)
REQ-024 Reset: rst=0 with sw_raw=16'hFFFF, then swcs=1, swread=1, swaddr=00 -> swrdata=16'h0000 and sw_changed=0 while rst is low.
REQ-025 Stable change: sw_raw 0000->A5A5, held -> deb=A5A5 and sw_changed=1 exactly at edge 7 after the change, not at edge 6.
REQ-026 Glitch: sw_raw=0001 for 3 cycles, then back to 0000 -> swrdata stays 0000 and sw_changed stays 0 for 20 cycles.
REQ-027 Read semantics: after REQ-025, status read -> 16'h0001 with sw_changed still 1; data read -> A5A5, and sw_changed=0 on the next edge. Data read on the same edge as a new acceptance -> sw_changed remains 1.
REQ-028 Reset mid-count: change to 00FF, assert rst at edge 5, release 2 cycles later with sw_raw still 00FF -> deb=0000 until 7 edges after release, then 00FF.
REQ-029 Macro undefined: sw_raw 0000->1234 -> deb=1234 and sw_changed=1 at edge 3; a 1-cycle glitch propagates to deb.
